// File: rtl/rv_nextpc_pred.sv
// -----------------------------------------------------------------------------
// rv_nextpc_pred
//   Fetch-stage next-PC unit. Holds the architectural fetch PC, predicts the
//   next PC through a direct-mapped BTB with 2-bit saturating counters,
//   resolves branches arriving from EX, raises a redirect on mispredict and
//   trains the BTB with the resolved outcome.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             hold the fetch PC (a redirect still wins)
//   pc                registered fetch PC
//   pred_taken        BTB predicts taken for pc
//   pred_target       predicted next PC for pc (pc+4 when not taken)
//   ex_valid          EX stage holds a valid instruction
//   ex_branch         branch kind (BR_NONE/BEQ/BNE/BLT/BGE/JAL/JALR)
//   ex_zero, ex_less  ALU flags for the conditional branch decision
//   ex_pc, ex_rs,
//   ex_imm            EX instruction PC, rs1 value and sign-extended immediate
//   ex_pred_taken,
//   ex_pred_target    prediction that travelled down the pipe with ex_pc
//   br_taken          resolved outcome of the EX instruction (comb)
//   redirect          mispredict: flush IF/ID and load redirect_pc (comb)
//   redirect_pc       correct next PC for the EX instruction (comb)
// -----------------------------------------------------------------------------
module rv_nextpc_pred #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BTB_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  ex_valid,
  input  logic [2:0]            ex_branch,
  input  logic                  ex_zero,
  input  logic                  ex_less,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_rs,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  output logic                  br_taken,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_pc
);

  // Branch kind encoding shared with the EX stage.
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_JAL  = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd6;

  localparam int unsigned IW = $clog2(BTB_DEPTH);
  localparam int unsigned TW = ADDR_WIDTH - IW - 2;
  localparam logic [ADDR_WIDTH-1:0] PC_INC = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

  // BTB storage
  logic                  valid_q [BTB_DEPTH];
  logic [TW-1:0]         tag_q   [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_q   [BTB_DEPTH];
  logic [1:0]            ctr_q   [BTB_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // Lookup side (fetch PC)
  logic [IW-1:0]         fe_idx_s;
  logic [TW-1:0]         fe_tag_s;
  logic                  fe_hit_s;
  logic                  pred_taken_s;
  logic [ADDR_WIDTH-1:0] pred_target_s;

  // Resolution side (EX instruction)
  logic [ADDR_WIDTH-1:0] imm_a_s, rs_a_s;
  logic [ADDR_WIDTH-1:0] jalr_sum_s;
  logic [ADDR_WIDTH-1:0] tgt_s;
  logic                  br_taken_s;
  logic                  redirect_s;
  logic [ADDR_WIDTH-1:0] redirect_pc_s;

  // Training side
  logic [IW-1:0]         ex_idx_s;
  logic [TW-1:0]         ex_tag_s;
  logic                  ex_hit_s;
  logic                  btb_we_s;
  logic                  valid_d;
  logic [TW-1:0]         tag_d;
  logic [ADDR_WIDTH-1:0] tgt_d;
  logic [1:0]            ctr_d;

  // Bring rs/imm to address width: truncate when wider, sign-extend the
  // immediate (and zero-extend rs) when narrower.
  if (DATA_WIDTH >= ADDR_WIDTH) begin : g_opnd_trunc
    assign imm_a_s = ex_imm[ADDR_WIDTH-1:0];
    assign rs_a_s  = ex_rs[ADDR_WIDTH-1:0];
  end else begin : g_opnd_ext
    assign imm_a_s = {{(ADDR_WIDTH-DATA_WIDTH){ex_imm[DATA_WIDTH-1]}}, ex_imm};
    assign rs_a_s  = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, ex_rs};
  end

  assign fe_idx_s = pc_q[IW+1:2];
  assign fe_tag_s = pc_q[ADDR_WIDTH-1:IW+2];
  assign ex_idx_s = ex_pc[IW+1:2];
  assign ex_tag_s = ex_pc[ADDR_WIDTH-1:IW+2];

  // BTB lookup for the current fetch PC; reads pre-update contents.
  always_comb begin
    fe_hit_s      = valid_q[fe_idx_s] & (tag_q[fe_idx_s] == fe_tag_s);
    pred_taken_s  = fe_hit_s & ctr_q[fe_idx_s][1];
    pred_target_s = pc_q + PC_INC;
    if (pred_taken_s) begin
      pred_target_s = tgt_q[fe_idx_s];
    end else begin
      pred_target_s = pc_q + PC_INC;
    end
  end

  // Resolve the EX instruction: outcome, target and mispredict detection.
  always_comb begin
    br_taken_s    = 1'b0;
    jalr_sum_s    = rs_a_s + imm_a_s;
    tgt_s         = ex_pc + imm_a_s;
    redirect_s    = 1'b0;
    redirect_pc_s = ex_pc + PC_INC;
    if (ex_branch == BR_JALR) begin
      tgt_s = {jalr_sum_s[ADDR_WIDTH-1:1], 1'b0};
    end else begin
      tgt_s = ex_pc + imm_a_s;
    end
    if (ex_valid) begin
      case (ex_branch)
        BR_BEQ:  br_taken_s = ex_zero;
        BR_BNE:  br_taken_s = ~ex_zero;
        BR_BLT:  br_taken_s = ex_less;
        BR_BGE:  br_taken_s = ~ex_less;
        BR_JAL:  br_taken_s = 1'b1;
        BR_JALR: br_taken_s = 1'b1;
        default: br_taken_s = 1'b0;
      endcase
      // A correct direction with a stale target is still a mispredict.
      redirect_s = (br_taken_s != ex_pred_taken) |
                   (br_taken_s & (tgt_s != ex_pred_target));
    end else begin
      br_taken_s = 1'b0;
      redirect_s = 1'b0;
    end
    if (br_taken_s) begin
      redirect_pc_s = tgt_s;
    end else begin
      redirect_pc_s = ex_pc + PC_INC;
    end
  end

  // Next fetch PC: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pred_target_s;
    if (redirect_s) begin
      pc_d = redirect_pc_s;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_target_s;
    end
  end

  // New contents of the BTB entry addressed by the EX instruction.
  always_comb begin
    btb_we_s = ex_valid & (ex_branch != BR_NONE);
    ex_hit_s = valid_q[ex_idx_s] & (tag_q[ex_idx_s] == ex_tag_s);
    valid_d  = valid_q[ex_idx_s];
    tag_d    = tag_q[ex_idx_s];
    tgt_d    = tgt_q[ex_idx_s];
    ctr_d    = ctr_q[ex_idx_s];
    if (br_taken_s) begin
      valid_d = 1'b1;
      tag_d   = ex_tag_s;
      tgt_d   = tgt_s;
      if (!ex_hit_s) begin
        ctr_d = 2'b10;                       // fresh entry starts weakly taken
      end else if (ctr_q[ex_idx_s] != 2'b11) begin
        ctr_d = ctr_q[ex_idx_s] + 2'd1;
      end else begin
        ctr_d = 2'b11;
      end
    end else if (ex_hit_s) begin
      if (ctr_q[ex_idx_s] != 2'b00) begin
        ctr_d = ctr_q[ex_idx_s] - 2'd1;
      end else begin
        ctr_d = 2'b00;
      end
    end else begin
      ctr_d = ctr_q[ex_idx_s];               // not-taken miss leaves entry alone
    end
  end

  // PC register and BTB array; training ignores stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= {TW{1'b0}};
        tgt_q[i]   <= {ADDR_WIDTH{1'b0}};
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (btb_we_s) begin
        valid_q[ex_idx_s] <= valid_d;
        tag_q[ex_idx_s]   <= tag_d;
        tgt_q[ex_idx_s]   <= tgt_d;
        ctr_q[ex_idx_s]   <= ctr_d;
      end
    end
  end

  assign pc          = pc_q;
  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;
  assign br_taken    = br_taken_s;
  assign redirect    = redirect_s;
  assign redirect_pc = redirect_pc_s;

endmodule
